// File: rtl/iir_stream_driver.sv
// ============================================================================
// Module   : iir_stream_driver
// Brief    : LFSR stimulus driver and MISR response compactor for the IIR
//            datapath overclocking test platform.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_stream_driver #(
    parameter int                 Stage       = 8,
    parameter int                 NUM_SAMPLES = 256,
    parameter int                 LATENCY     = 1,
    parameter logic [2*Stage-1:0] POLY        = 16'hB400
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*Stage-1:0]   seed,
    output logic                 busy,
    output logic                 done,
    output logic                 dut_enable,
    output logic [2*Stage-1:0]   dut_din,
    input  logic [2*Stage-1:0]   dut_dout,
    output logic [2*Stage-1:0]   signature,
    output logic [15:0]          sample_count
);

    localparam int         WL           = 2 * Stage;
    localparam logic [15:0] C_LAST_CNT  = 16'(NUM_SAMPLES - 1);
    localparam logic [3:0]  C_LAST_FLSH = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WL-1:0]      r_lfsr;
    logic [WL-1:0]      w_lfsr_next;
    logic [WL-1:0]      r_din;
    logic [WL-1:0]      r_sig;
    logic [15:0]        r_count;
    logic [3:0]         r_flush;
    logic               r_busy;
    logic               r_done;
    logic               r_enable;
    logic [LATENCY-1:0] r_vld;
    logic               w_accept;
    logic               w_capture;

    // Galois shift shared by the sample generator and the signature register
    function automatic logic [WL-1:0] galois_step(input logic [WL-1:0] v);
        return (v >> 1) ^ (v[0] ? POLY : '0);
    endfunction

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_capture = r_vld[LATENCY-1];

    always_comb begin
        w_next      = r_state;
        w_lfsr_next = r_lfsr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next      = S_RUN;
                    w_lfsr_next = (seed == '0) ? WL'(1) : seed;
                end
            end
            S_RUN: begin
                w_lfsr_next = galois_step(r_lfsr);
                if (r_count == C_LAST_CNT) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_flush == C_LAST_FLSH) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lfsr   <= '0;
            r_din    <= '0;
            r_sig    <= '0;
            r_count  <= '0;
            r_flush  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_lfsr   <= w_lfsr_next;
            // Outputs are decoded from the next state so they change on the same edge as the FSM
            r_din    <= (w_next == S_RUN) ? w_lfsr_next : '0;
            r_busy   <= (w_next == S_RUN) || (w_next == S_FLUSH);
            r_enable <= (w_next == S_RUN) || (w_next == S_FLUSH);
            r_done   <= (w_next == S_DONE);
            r_flush  <= (r_state == S_FLUSH) ? r_flush + 4'd1 : 4'd0;
            if (w_accept) begin
                r_count <= '0;
                r_sig   <= '0;
            end else begin
                if (r_state == S_RUN) begin
                    r_count <= r_count + 16'd1;
                end
                if (w_capture) begin
                    r_sig <= galois_step(r_sig) ^ dut_dout;
                end
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_vld_single
            always_ff @(posedge clk) begin
                if (rst || w_accept) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= (r_state == S_RUN);
                end
            end
        end else begin : g_vld_shift
            always_ff @(posedge clk) begin
                if (rst || w_accept) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= {r_vld[LATENCY-2:0], (r_state == S_RUN)};
                end
            end
        end
    endgenerate

    assign busy         = r_busy;
    assign done         = r_done;
    assign dut_enable   = r_enable;
    assign dut_din      = r_din;
    assign signature    = r_sig;
    assign sample_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_iir_stream_driver.sv
// ============================================================================
// Module   : tb_iir_stream_driver
// Brief    : Self-checking bench: loopback/constant stubs on a short run and a
//            stand-in recursive filter on a full-length run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iir_stream_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [15:0] seed, seed2;
    logic        mode;

    logic        busy, done, en;
    logic [15:0] din, dout, sig, cnt, lb;
    logic        busy2, done2, en2;
    logic [15:0] din2, dout2, sig2, cnt2;
    logic [15:0] y2, p1, p2;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    iir_stream_driver #(.Stage(8), .NUM_SAMPLES(4), .LATENCY(1), .POLY(16'hB400)) u_dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .busy(busy), .done(done), .dut_enable(en), .dut_din(din),
        .dut_dout(dout), .signature(sig), .sample_count(cnt)
    );

    iir_stream_driver #(.Stage(8), .NUM_SAMPLES(256), .LATENCY(3), .POLY(16'hB400)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .seed(seed2),
        .busy(busy2), .done(done2), .dut_enable(en2), .dut_din(din2),
        .dut_dout(dout2), .signature(sig2), .sample_count(cnt2)
    );

    // Short-run stub: one-cycle loopback or a constant all-ones output
    always_ff @(posedge clk) lb <= din;
    assign dout = mode ? 16'hFFFF : lb;

    // Stand-in recursive filter with three cycles from input to output
    always_ff @(posedge clk) begin
        y2 <= en2 ? ((y2 >> 1) ^ din2) : 16'h0000;
        p1 <= y2;
        p2 <= p1;
    end
    assign dout2 = p2;

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 4-sample run; checks every cycle from 1 to 7 plus the held signature
    task automatic run_small(input logic [15:0] s, input logic m, input logic poke,
                             input logic [15:0] exp_sig);
        logic [15:0] x;
        int dones;
        mode = m;
        seed = s;
        x = (s == 16'h0) ? 16'h0001 : s;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(x);
            x = step(x);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 7; c++) begin
            check("busy", busy, 32'(c <= 5));
            check("done", done, 32'(c == 6));
            dones += int'(done);
            check("enable", en, 32'(c <= 5));
            check("din", din, (c <= 4) ? 32'(exp_q.pop_front()) : 32'h0);
            check("count", cnt, (c <= 4) ? 32'(c - 1) : 32'd4);
            if (c == 6) check("signature", sig, exp_sig);
            start = poke && (c == 2 || c == 5);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_pulses", dones, 1);
        check("signature_hold", sig, exp_sig);
    endtask

    task automatic run_big(output logic [15:0] got);
        int n;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("big_done_seen", done2, 1);
        check("big_done_cycle", n, 259);
        check("big_count", cnt2, 256);
        got = sig2;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] x, y, s, sig_a, sig_b;

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        seed = 16'h0; seed2 = 16'hACE1; mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_enable", en, 0);
        check("rst_din", din, 0);
        check("rst_sig", sig, 0);
        check("rst_count", cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        run_small(16'h0001, 1'b0, 1'b0, 16'h0000);
        run_small(16'h0001, 1'b1, 1'b0, 16'h3900);
        run_small(16'h0000, 1'b0, 1'b0, 16'h0000);
        run_small(16'h0001, 1'b0, 1'b1, 16'h0000);

        // Reset asserted during cycle 2 of a constant-output run
        mode = 1'b1; seed = 16'h0001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_enable", en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sig", sig, 0);
        check("mid_rst_count", cnt, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_din", din, 0);
        @(posedge clk); #1;
        check("mid_rst_idle", busy, 0);
        run_small(16'h0001, 1'b0, 1'b0, 16'h0000);

        // Full-length run against the stand-in filter model
        x = 16'hACE1; y = 16'h0; s = 16'h0;
        for (int k = 0; k < 256; k++) begin
            y = (y >> 1) ^ x;
            s = step(s) ^ y;
            x = step(x);
        end
        run_big(sig_a);
        run_big(sig_b);
        check("big_sig_model", sig_a, s);
        check("big_sig_repeat", sig_b, sig_a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
